asym_fifo_sync: RTL and testbench

- Single-clock FIFO with asymmetric port widths; successor to the simple-dual-port asymmetric RAM.
- Supports either write-wider or read-wider through one parameter set, with valid/ready handshakes on both sides.
- Tracks occupancy and provides full/empty, a level count and a synchronous flush.
- Sits between wide DSP/DMA buses and narrow consumers (e.g. 64-bit command stream to 16-bit sequencer) inside one clock domain.

---
 rtl/asym_fifo_pkg.sv | 35 +++
 rtl/asym_fifo_sync_if.sv | 26 ++
 rtl/asym_ram_sdp_1clk.sv | 47 ++++
 rtl/asym_fifo_sync.sv | 94 +++++++++
 tb/tb_asym_fifo_sync.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared width/depth arithmetic for the asymmetric FIFO and its storage array.
package asym_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Storage granule: the narrower of the two port widths.
    function automatic int minw(input int wr_width, input int rd_width);
        return min(wr_width, rd_width);
    endfunction

    function automatic int ratio(input int wr_width, input int rd_width);
        return max(wr_width, rd_width) / min(wr_width, rd_width);
    endfunction

    // Units moved per transfer on a port of width port_width: 1 or RATIO.
    function automatic int port_units(input int port_width, input int wr_width, input int rd_width);
        return port_width / minw(wr_width, rd_width);
    endfunction

endpackage

// File: rtl/asym_fifo_sync_if.sv
// Write/read handshake and status bundle for asym_fifo_sync; master is the producer/consumer side.
interface asym_fifo_sync_if #(
    parameter int WR_WIDTH    = 64,
    parameter int RD_WIDTH    = 16,
    parameter int LEVEL_WIDTH = 11
);
    logic [WR_WIDTH-1:0]    wr_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [RD_WIDTH-1:0]    rd_data;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   full;
    logic                   empty;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid, level, full, empty
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid, level, full, empty
    );
endinterface

// File: rtl/asym_ram_sdp_1clk.sv
// Single-clock simple-dual-port array stored in min-width units; one-cycle registered read.
// No backpressure: caller gates i_wr_en/i_rd_en; i_clr zeroes only the read register.
module asym_ram_sdp_1clk
    import asym_fifo_pkg::*;
#(
    parameter int WR_WIDTH    = 64,
    parameter int RD_WIDTH    = 16,
    parameter int DEPTH_UNITS = 1024
) (
    input  logic                            clk,
    input  logic                            i_clr,
    input  logic                            i_wr_en,
    input  logic [clog2(DEPTH_UNITS)-1:0]   i_wr_addr,
    input  logic [WR_WIDTH-1:0]             i_wr_data,
    input  logic                            i_rd_en,
    input  logic [clog2(DEPTH_UNITS)-1:0]   i_rd_addr,
    output logic [RD_WIDTH-1:0]             o_rd_data
);
    localparam int AW       = clog2(DEPTH_UNITS);
    localparam int MINW     = minw(WR_WIDTH, RD_WIDTH);
    localparam int WR_UNITS = port_units(WR_WIDTH, WR_WIDTH, RD_WIDTH);
    localparam int RD_UNITS = port_units(RD_WIDTH, WR_WIDTH, RD_WIDTH);

    logic [MINW-1:0]     r_mem [DEPTH_UNITS];
    logic [RD_WIDTH-1:0] r_rd_data;

    // Lane i lives at address+i, so the LSB lane is always the earliest unit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < WR_UNITS; i++) begin
                r_mem[i_wr_addr + AW'(i)] <= i_wr_data[i*MINW +: MINW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            for (int i = 0; i < RD_UNITS; i++) begin
                r_rd_data[i*MINW +: MINW] <= r_mem[i_rd_addr + AW'(i)];
            end
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/asym_fifo_sync.sv
// Single-clock asymmetric-width FIFO with one registered output word; a completing write shows on rd_valid one cycle later.
// Backpressure: wr_ready drops when fewer than one write word of units is free; rd_data/rd_valid hold until rd_ready.
module asym_fifo_sync
    import asym_fifo_pkg::*;
#(
    parameter int WR_WIDTH    = 64,
    parameter int RD_WIDTH    = 16,
    parameter int DEPTH_UNITS = 1024,
    parameter int LEVEL_WIDTH = 11
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    asym_fifo_sync_if.slave bus
);
    localparam int AW = clog2(DEPTH_UNITS);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] WR_U  = PW'(port_units(WR_WIDTH, WR_WIDTH, RD_WIDTH));
    localparam logic [PW-1:0] RD_U  = PW'(port_units(RD_WIDTH, WR_WIDTH, RD_WIDTH));
    localparam logic [PW-1:0] DEPTH = PW'(DEPTH_UNITS);

    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic                r_rd_valid, r_wr_ready, r_full, r_empty;
    logic [PW-1:0]       w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [PW-1:0]       w_ram_units, w_ram_nxt, w_level_nxt;
    logic                w_rd_valid_nxt, w_wr_ready_nxt;
    logic                w_clr, w_wr_fire, w_load;
    logic [RD_WIDTH-1:0] w_rd_data;

    // Pointers carry a wrap bit, so their difference is the unread RAM occupancy.
    assign w_ram_units = r_wr_ptr - r_rd_ptr;
    assign w_clr       = !rstn || flush;
    assign w_wr_fire   = bus.wr_valid && r_wr_ready;
    assign w_load      = (!r_rd_valid || bus.rd_ready) && (w_ram_units >= RD_U);

    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_rd_valid_nxt = r_rd_valid;
        if (w_wr_fire) begin
            w_wr_ptr_nxt = r_wr_ptr + WR_U;
        end
        if (w_load) begin
            w_rd_ptr_nxt   = r_rd_ptr + RD_U;
            w_rd_valid_nxt = 1'b1;
        end else if (r_rd_valid && bus.rd_ready) begin
            w_rd_valid_nxt = 1'b0;
        end
    end

    assign w_ram_nxt      = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_level_nxt    = w_ram_nxt + (w_rd_valid_nxt ? RD_U : '0);
    assign w_wr_ready_nxt = (DEPTH - w_ram_nxt) >= WR_U;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b1;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_wr_ready <= w_wr_ready_nxt;
            r_full     <= !w_wr_ready_nxt;
            r_empty    <= (w_level_nxt == '0);
        end
    end

    asym_ram_sdp_1clk #(
        .WR_WIDTH    (WR_WIDTH),
        .RD_WIDTH    (RD_WIDTH),
        .DEPTH_UNITS (DEPTH_UNITS)
    ) u_ram (
        .clk       (clk),
        .i_clr     (w_clr),
        .i_wr_en   (w_wr_fire && !w_clr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_load && !w_clr),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.wr_ready = r_wr_ready;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.level    = LEVEL_WIDTH'(w_ram_units + (r_rd_valid ? RD_U : '0));
endmodule

// File: tb/tb_asym_fifo_sync.sv
// Bench for asym_fifo_sync: a 64->16 instance and a 16->64 instance driven from one clock.
module tb_asym_fifo_sync;
    logic clk = 1'b0;
    logic rstn, fa, fb;
    always #5 clk = ~clk;

    asym_fifo_sync_if #(.WR_WIDTH(64), .RD_WIDTH(16), .LEVEL_WIDTH(11)) ia ();
    asym_fifo_sync_if #(.WR_WIDTH(16), .RD_WIDTH(64), .LEVEL_WIDTH(11)) ib ();

    asym_fifo_sync #(.WR_WIDTH(64), .RD_WIDTH(16), .DEPTH_UNITS(1024), .LEVEL_WIDTH(11)) u_a (
        .clk(clk), .rstn(rstn), .flush(fa), .bus(ia.slave));
    asym_fifo_sync #(.WR_WIDTH(16), .RD_WIDTH(64), .DEPTH_UNITS(1024), .LEVEL_WIDTH(11)) u_b (
        .clk(clk), .rstn(rstn), .flush(fb), .bus(ib.slave));

    int n_chk = 0;
    int n_fail = 0;
    int pops_a = 0;
    int pops_b = 0;
    int bcnt = 0;
    int wseq = 0;
    logic [15:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] bacc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_word(input int n);
        return {16'(4*n+3), 16'(4*n+2), 16'(4*n+1), 16'(4*n)};
    endfunction

    // Scoreboard: accepted writes push expected lanes, each read handshake pops one.
    always @(negedge clk) begin
        if (!rstn || fa) begin
            qa.delete();
        end else begin
            if (ia.wr_valid && ia.wr_ready)
                for (int i = 0; i < 4; i++) qa.push_back(ia.wr_data[i*16 +: 16]);
            if (ia.rd_valid && ia.rd_ready) begin
                chk("a_sb_has_word", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    chk("a_rd_data", 64'(ia.rd_data), 64'(qa.pop_front()));
                    pops_a++;
                end
            end
        end
        if (!rstn || fb) begin
            qb.delete();
            bcnt = 0;
        end else begin
            if (ib.wr_valid && ib.wr_ready) begin
                bacc[bcnt*16 +: 16] = ib.wr_data;
                bcnt++;
                if (bcnt == 4) begin
                    qb.push_back(bacc);
                    bcnt = 0;
                end
            end
            if (ib.rd_valid && ib.rd_ready) begin
                chk("b_sb_has_word", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) begin
                    chk("b_rd_data", ib.rd_data, qb.pop_front());
                    pops_b++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim_time=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int acc, w, p0;
        rstn = 1'b0; fa = 1'b0; fb = 1'b0;
        ia.wr_valid = 1'b0; ia.wr_data = '0; ia.rd_ready = 1'b0;
        ib.wr_valid = 1'b0; ib.wr_data = '0; ib.rd_ready = 1'b0;
        repeat (3) step();
        chk("rst_a_level", 64'(ia.level), 64'd0);
        chk("rst_a_empty", 64'(ia.empty), 64'd1);
        chk("rst_a_full", 64'(ia.full), 64'd0);
        chk("rst_a_wr_ready", 64'(ia.wr_ready), 64'd1);
        chk("rst_a_rd_valid", 64'(ia.rd_valid), 64'd0);
        chk("rst_a_rd_data", 64'(ia.rd_data), 64'd0);
        chk("rst_b_level", 64'(ib.level), 64'd0);
        chk("rst_b_empty", 64'(ib.empty), 64'd1);
        rstn = 1'b1;
        step();

        // Write-wider: one word splits into four reads, LSB lane first.
        ia.rd_ready = 1'b1;
        ia.wr_valid = 1'b1;
        ia.wr_data  = 64'h4444_3333_2222_1111;
        step();
        ia.wr_valid = 1'b0;
        chk("t1_rv_at_wr_edge", 64'(ia.rd_valid), 64'd0);
        chk("t1_level_at_wr_edge", 64'(ia.level), 64'd4);
        step();
        chk("t1_rv_latency", 64'(ia.rd_valid), 64'd1);
        chk("t1_first_lane", 64'(ia.rd_data), 64'h1111);
        chk("t1_level_4", 64'(ia.level), 64'd4);
        for (int k = 3; k >= 0; k--) begin
            step();
            chk("t1_level_step", 64'(ia.level), 64'(k));
        end
        chk("t1_empty", 64'(ia.empty), 64'd1);

        // Read-wider: partial word stays hidden until the fourth lane lands.
        ib.rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ib.wr_valid = 1'b1;
            ib.wr_data  = 16'(16'hAAAA + k * 16'h1111);
            step();
        end
        ib.wr_valid = 1'b0;
        step(); step();
        chk("t2_rv_partial", 64'(ib.rd_valid), 64'd0);
        chk("t2_level_partial", 64'(ib.level), 64'd3);
        ib.wr_valid = 1'b1;
        ib.wr_data  = 16'hDDDD;
        step();
        ib.wr_valid = 1'b0;
        chk("t2_rv_at_wr_edge", 64'(ib.rd_valid), 64'd0);
        step();
        chk("t2_rv_latency", 64'(ib.rd_valid), 64'd1);
        chk("t2_rd_word", ib.rd_data, 64'hDDDD_CCCC_BBBB_AAAA);
        chk("t2_level", 64'(ib.level), 64'd4);
        step();
        chk("t2_empty", 64'(ib.empty), 64'd1);

        // Fill with the consumer stalled.
        ia.rd_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 400 && ia.wr_ready; c++) begin
            ia.wr_valid = 1'b1;
            ia.wr_data  = mk_word(wseq);
            wseq++;
            acc++;
            step();
        end
        chk("t3_accepted", 64'(acc), 64'd256);
        chk("t3_full", 64'(ia.full), 64'd1);
        chk("t3_wr_ready", 64'(ia.wr_ready), 64'd0);
        ia.wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        ia.wr_valid = 1'b0;
        chk("t3_level_full", 64'(ia.level), 64'd1024);
        chk("t3_full_hold", 64'(ia.full), 64'd1);

        // Simultaneous write and read at level 1020.
        ia.rd_ready = 1'b1;
        for (int c = 0; c < 10 && ia.level != 11'd1020; c++) step();
        chk("t4_level_pre", 64'(ia.level), 64'd1020);
        chk("t4_wr_ready_pre", 64'(ia.wr_ready), 64'd1);
        ia.wr_valid = 1'b1;
        ia.wr_data  = mk_word(wseq);
        wseq++;
        step();
        ia.wr_valid = 1'b0;
        ia.rd_ready = 1'b0;
        chk("t4_level_post", 64'(ia.level), 64'd1023);
        chk("t4_full_post", 64'(ia.full), 64'd1);
        chk("t4_wr_ready_post", 64'(ia.wr_ready), 64'd0);
        ia.rd_ready = 1'b1;
        for (int c = 0; c < 2000 && !ia.empty; c++) step();
        chk("t4_drained", 64'(ia.empty), 64'd1);
        chk("t4_sb_empty", 64'(qa.size()), 64'd0);

        // Flush mid-stream with a concurrent write.
        ia.rd_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ia.wr_valid = 1'b1;
            ia.wr_data  = mk_word(wseq);
            wseq++;
            step();
        end
        ia.wr_valid = 1'b0;
        ia.rd_ready = 1'b1;
        for (int c = 0; c < 10 && ia.level != 11'd37; c++) step();
        chk("t5_level_pre", 64'(ia.level), 64'd37);
        ia.wr_valid = 1'b1;
        ia.wr_data  = mk_word(wseq);
        wseq++;
        fa = 1'b1;
        step();
        fa = 1'b0;
        ia.wr_valid = 1'b0;
        chk("t5_level", 64'(ia.level), 64'd0);
        chk("t5_empty", 64'(ia.empty), 64'd1);
        chk("t5_rd_valid", 64'(ia.rd_valid), 64'd0);
        chk("t5_rd_data", 64'(ia.rd_data), 64'd0);
        chk("t5_wr_ready", 64'(ia.wr_ready), 64'd1);
        ia.wr_valid = 1'b1;
        ia.wr_data  = 64'h8888_7777_6666_5555;
        step();
        ia.wr_valid = 1'b0;
        step();
        chk("t5_post_flush_lane0", 64'(ia.rd_data), 64'h5555);
        for (int c = 0; c < 20 && !ia.empty; c++) step();
        chk("t5_sb_empty", 64'(qa.size()), 64'd0);

        // Random streaming across several pointer wraps, write-wider.
        w = 0;
        p0 = pops_a;
        for (int c = 0; c < 30000 && (w < 2000 || !ia.empty); c++) begin
            ia.wr_valid = (w < 2000) && ($urandom_range(0, 3) != 0);
            ia.wr_data  = mk_word(wseq);
            ia.rd_ready = ($urandom_range(0, 3) != 0);
            if (ia.wr_valid && ia.wr_ready) begin
                wseq++;
                w++;
            end
            step();
        end
        ia.wr_valid = 1'b0;
        chk("t6_words_written", 64'(w), 64'd2000);
        chk("t6_reads", 64'(pops_a - p0), 64'd8000);
        chk("t6_sb_empty", 64'(qa.size()), 64'd0);

        // Random streaming, read-wider.
        w = 0;
        p0 = pops_b;
        for (int c = 0; c < 10000 && (w < 400 || !ib.empty); c++) begin
            ib.wr_valid = (w < 400) && ($urandom_range(0, 1) != 0);
            ib.wr_data  = 16'(w * 7 + 3);
            ib.rd_ready = ($urandom_range(0, 2) != 0);
            if (ib.wr_valid && ib.wr_ready) w++;
            step();
        end
        ib.wr_valid = 1'b0;
        chk("t7_words_written", 64'(w), 64'd400);
        chk("t7_reads", 64'(pops_b - p0), 64'd100);
        chk("t7_sb_empty", 64'(qb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
